// File: rtl/laser_pkg.sv
// Shared encodings and lane geometry for the laser sweep obstacle.
package laser_pkg;

    typedef enum logic [1:0] {
        MODE_FWD  = 2'b00,
        MODE_PING = 2'b01,
        MODE_ALL  = 2'b10,
        MODE_RSVD = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_GROW = 2'b01,
        S_HOLD = 2'b10
    } state_t;

    // Left core column of a lane; right core column is this plus one.
    function automatic logic [11:0] core_left(input int first_left, input int pitch, input int idx);
        return 12'(first_left + idx * pitch);
    endfunction

endpackage

// File: rtl/laser_tick_counter.sv
// Terminal-count tick counter; wraps to zero on tc, clear has priority over enable.
module laser_tick_counter #(
    parameter int CW = 8
) (
    input  logic          pclk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [CW-1:0] last,
    output logic          tc
);

    logic [CW-1:0] count;

    assign tc = en && (count == last);

    always_ff @(posedge pclk) begin
        if (rst || clr)
            count <= '0;
        else if (en)
            count <= tc ? '0 : count + CW'(1);
    end

endmodule

// File: rtl/laser_sweep_obstacle.sv
// Laser obstacle generator: sweeps growing vertical beams across lanes and
// overlays them on the rgb stream, reporting beam pixels as obstacles.
module laser_sweep_obstacle
    import laser_pkg::*;
#(
    parameter int          N_LASERS     = 3,
    parameter int          FIRST_LEFT   = 411,
    parameter int          PITCH        = 100,
    parameter int          LASER_TOP    = 317,
    parameter int          LASER_BOTTOM = 617,
    parameter int          HW_MAX       = 25,
    parameter int          GROW_TICKS   = 3_250_000,
    parameter int          HOLD_TICKS   = 32_500_000,
    parameter logic [11:0] LASER_RGB    = 12'hfff
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic [11:0] hcount_in,
    input  logic [11:0] vcount_in,
    input  logic [11:0] rgb_in,
    input  logic        start,
    input  logic        abort,
    input  logic [1:0]  mode,
    output logic [11:0] rgb_out,
    output logic [11:0] obstacle_x,
    output logic [11:0] obstacle_y,
    output logic        on_beam,
    output logic        working,
    output logic        done
);

    localparam int TMAX = (GROW_TICKS > HOLD_TICKS) ? GROW_TICKS : HOLD_TICKS;
    localparam int CW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int LW   = (N_LASERS > 1) ? $clog2(N_LASERS) : 1;

    localparam logic [CW-1:0] GROW_LAST = CW'(GROW_TICKS - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_TICKS - 1);
    localparam logic [LW-1:0] LANE_LAST = LW'(N_LASERS - 1);
    localparam logic [11:0]   HW_FULL   = 12'(HW_MAX);
    localparam logic [11:0]   TOP_ROW   = 12'(LASER_TOP);
    localparam logic [11:0]   BOT_ROW   = 12'(LASER_BOTTOM);

    state_t        state, state_nx;
    mode_t         mode_q, mode_nx;
    logic [LW-1:0] lane, lane_nx;
    logic          dir, dir_nx;     // 0: lanes ascending, 1: descending (ping-pong return)
    logic [11:0]   hw, hw_nx;
    logic          done_nx;
    logic          seq_end;
    logic          tc;

    laser_tick_counter #(.CW(CW)) u_tick (
        .pclk (pclk),
        .rst  (rst),
        .clr  (state_nx != state),
        .en   (state != S_IDLE),
        .last ((state == S_HOLD) ? HOLD_LAST : GROW_LAST),
        .tc   (tc)
    );

    always_ff @(posedge pclk) begin
        if (rst) begin
            state  <= S_IDLE;
            mode_q <= MODE_FWD;
            lane   <= '0;
            dir    <= 1'b0;
            hw     <= '0;
            done   <= 1'b0;
        end else begin
            state  <= state_nx;
            mode_q <= mode_nx;
            lane   <= lane_nx;
            dir    <= dir_nx;
            hw     <= hw_nx;
            done   <= done_nx;
        end
    end

    always_comb begin
        state_nx = state;
        mode_nx  = mode_q;
        lane_nx  = lane;
        dir_nx   = dir;
        hw_nx    = hw;
        done_nx  = 1'b0;
        seq_end  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_GROW;
                    mode_nx  = (mode == MODE_RSVD) ? MODE_FWD : mode_t'(mode);
                    lane_nx  = '0;
                    dir_nx   = 1'b0;
                    hw_nx    = '0;
                end
            end
            S_GROW: begin
                if (tc) begin
                    hw_nx = hw + 12'd1;
                    if (hw + 12'd1 == HW_FULL)
                        state_nx = S_HOLD;
                end
            end
            S_HOLD: begin
                if (tc) begin
                    state_nx = S_GROW;
                    hw_nx    = '0;
                    if (mode_q == MODE_ALL || N_LASERS == 1) begin
                        seq_end = 1'b1;
                    end else if (mode_q == MODE_PING) begin
                        if (!dir && lane == LANE_LAST) begin
                            dir_nx  = 1'b1;
                            lane_nx = lane - LW'(1);
                        end else if (dir && lane == '0) begin
                            seq_end = 1'b1;
                        end else begin
                            lane_nx = dir ? lane - LW'(1) : lane + LW'(1);
                        end
                    end else begin
                        if (lane == LANE_LAST)
                            seq_end = 1'b1;
                        else
                            lane_nx = lane + LW'(1);
                    end
                    if (seq_end) begin
                        state_nx = S_IDLE;
                        lane_nx  = '0;
                        dir_nx   = 1'b0;
                        done_nx  = 1'b1;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
        // Abort outranks start, terminal counts and sequence end alike.
        if (abort) begin
            state_nx = S_IDLE;
            lane_nx  = '0;
            dir_nx   = 1'b0;
            hw_nx    = '0;
            done_nx  = 1'b0;
        end
    end

    assign working = (state != S_IDLE);

    logic [N_LASERS-1:0] hit;
    logic                row_ok;

    assign row_ok = (vcount_in >= TOP_ROW) && (vcount_in <= BOT_ROW);

    for (genvar i = 0; i < N_LASERS; i++) begin : g_lane
        localparam logic [11:0] CL = core_left(FIRST_LEFT, PITCH, i);
        logic lane_on;
        assign lane_on = working && (mode_q == MODE_ALL || lane == LW'(i));
        assign hit[i]  = lane_on && row_ok &&
                         (hcount_in >= CL - hw) && (hcount_in <= CL + 12'd1 + hw);
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            rgb_out    <= '0;
            obstacle_x <= '0;
            obstacle_y <= '0;
            on_beam    <= 1'b0;
        end else if (|hit) begin
            rgb_out    <= LASER_RGB;
            obstacle_x <= hcount_in;
            obstacle_y <= vcount_in;
            on_beam    <= 1'b1;
        end else begin
            rgb_out    <= rgb_in;
            obstacle_x <= '0;
            obstacle_y <= '0;
            on_beam    <= 1'b0;
        end
    end

endmodule

// File: doc/laser_sweep_obstacle.md
# laser_sweep_obstacle

Parametrised laser-obstacle generator for the game arena. It draws up to N_LASERS vertical beams between fixed top and bottom rows, grows each beam outward from a 2-pixel core, holds it at full width, then advances to the next lane. Supported sequences are forward, ping-pong and all-lanes-at-once. It sits in the rgb pipeline between the background/arena stage and the player/collision stage, and reports every beam pixel as an obstacle coordinate for collision detection.

## Interface
- N_LASERS, 3: number of lanes, 1..8
- FIRST_LEFT, 411: left core column of lane 0; lane i core = FIRST_LEFT + i*PITCH, FIRST_LEFT + i*PITCH + 1
- PITCH, 100: column distance between lane cores
- LASER_TOP, 317 / LASER_BOTTOM, 617: inclusive vertical extent
- HW_MAX, 25: final half-width growth in pixels
- GROW_TICKS, 3_250_000: cycles per 1-pixel growth step
- HOLD_TICKS, 32_500_000: cycles a beam stays at full width
- LASER_RGB, 12'hfff: beam colour
- pclk  in  1  pixel clock
- rst  in  1  reset; synchronous, active-high; clock pclk
- hcount_in, vcount_in  in  12 each  current pixel position
- rgb_in  in  12  upstream colour
- start  in  1  one-cycle request to begin a sequence; ignored unless IDLE
- abort  in  1  level; return to IDLE immediately (menu entered or play deselected)
- mode  in  2  00 forward, 01 ping-pong, 10 all lanes, 11 treated as forward; sampled on accepted start
- rgb_out  out  12  registered colour
- obstacle_x, obstacle_y  out  12 each  pixel coordinate when on a beam, else 0
- on_beam  out  1  current registered pixel is a beam pixel
- working  out  1  high while not IDLE
- done  out  1  one-cycle pulse when a sequence completes normally

## Operation
- States: IDLE, GROW, HOLD.
- IDLE: hw=0, counters=0, lane=0, dir=up. Accepted start latches mode, sets lane=0, and enters GROW.
- GROW: tick counter runs 0..GROW_TICKS-1. At the terminal count hw increments and the counter clears. When hw reaches HW_MAX, the FSM enters HOLD with the counter cleared.
- HOLD: counter runs 0..HOLD_TICKS-1. At the terminal count the FSM advances the lane with hw=0 and enters GROW; if the sequence has ended, it pulses done and goes to IDLE.
- Lane order:
  - forward: 0..N-1.
  - ping-pong: 0..N-1..0, with 2N-1 lanes visited; the turning lane is not repeated.
  - all lanes: a single pass in which every lane is active simultaneously.
  - N_LASERS=1: every mode is one lane pass.
- Active beam, lane i: columns [core_left_i - hw, core_left_i + 1 + hw] and rows [LASER_TOP, LASER_BOTTOM], all inclusive. Only the current lane is active, except in all-lanes mode where every lane is active. No beam is drawn in IDLE.
- Pixel path: if the pixel is on an active beam, rgb_out=LASER_RGB, obstacle_x/y=hcount/vcount and on_beam=1. Otherwise rgb_out=rgb_in, obstacle_x/y=0 and on_beam=0.
- Width rules: column bounds are computed in 12 bits. Parameter legality requires FIRST_LEFT ≥ HW_MAX and a last lane right edge ≤ 4095, so no wrap occurs. Counter width is $clog2(max(GROW_TICKS,HOLD_TICKS)).
- Abort has priority over everything, including a simultaneous start, a terminal count, or the end of the sequence. On abort: next state IDLE, no done pulse.
- start while busy is ignored; the latched mode is unchanged.

## Timing
- Reset values: rgb_out=0, obstacle_x=0, obstacle_y=0, on_beam=0, working=0, done=0, state IDLE.
- Pixel path latency is 1 cycle from hcount/vcount/rgb_in to the outputs.
- Start accepted at edge k: working=1 after edge k, and beam core pixels are drawn from edge k+1.
- Lane pass length L = HW_MAX*GROW_TICKS + HOLD_TICKS cycles.
- done asserts for exactly one cycle after edge k + P*L, where P is N (forward), 2N-1 (ping-pong) or 1 (all lanes). working drops on that same edge.
- Abort at edge j: working=0 after edge j and no beam pixel from edge j+1. rst mid-sequence behaves the same way.

## Structure
- Package laser_pkg holds the mode and state encodings and the lane-core function core_left(i).
- Sub-module laser_tick_counter: a parametrised terminal-count counter with clear/enable and a one-cycle tc output. It is instantiated once and shared by GROW and HOLD, reloaded on each state change.
- The top level holds the FSM, the lane/direction logic, the beam compare loop over N_LASERS and the output registers.

## Test plan
All scenarios use N=3, GROW_TICKS=2, HOLD_TICKS=4, HW_MAX=2, giving L=8.
- Forward: start at edge 0, mode 00 → lane sequence 0,1,2; done pulse after edge 24 only; working high over edges 0..23.
- Ping-pong: start, mode 01 → lane sequence 0,1,2,1,0; done after edge 40.
- All lanes: start, mode 10 → columns 409..414, 509..514 and 609..614 all white at full width on rows 317..617; done after edge 8.
- Pixel check during lane 0 full width: pixel (409,317) → rgb_out=fff, obstacle=(409,317). Pixel (408,317) or (409,316) → rgb_out=rgb_in, obstacle=(0,0).
- Abort mid-HOLD asserted together with start → IDLE on the next edge, no done, no further beam pixels; a later start restarts at lane 0 with hw=0.
- rst mid-GROW → all outputs at reset values; start issued while busy → ignored and the latched mode is unchanged.
